// File: rtl/reg_file_read.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_read
// Brief    : MIPS register file with write-before-read bypass and registered
//            ID/EX read outputs (stall hold with refresh, flush to bubble).
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_read #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [ADDR_W-1:0] rs_addr_q,
    output logic [ADDR_W-1:0] rt_addr_q
);

    localparam int c_NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [c_NUM_REGS];
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [ADDR_W-1:0] r_rs_addr_q;
    logic [ADDR_W-1:0] r_rt_addr_q;

    logic              w_weff;
    logic [DATA_W-1:0] w_rs_lookup;
    logic [DATA_W-1:0] w_rt_lookup;

    assign w_weff = wr_en && (wr_addr != '0);

    always_comb begin
        w_rs_lookup = r_regs[rs_addr];
        if (rs_addr == '0) begin
            w_rs_lookup = '0;
        end else if (w_weff && (wr_addr == rs_addr)) begin
            w_rs_lookup = wr_data;
        end
    end

    always_comb begin
        w_rt_lookup = r_regs[rt_addr];
        if (rt_addr == '0) begin
            w_rt_lookup = '0;
        end else if (w_weff && (wr_addr == rt_addr)) begin
            w_rt_lookup = wr_data;
        end
    end

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_weff) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_rs_addr_q <= '0;
            r_rt_addr_q <= '0;
        end else if (flush) begin
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_rs_addr_q <= '0;
            r_rt_addr_q <= '0;
        end else if (stall) begin
            // A held operand tracks writebacks to its own register so it cannot go stale.
            if (w_weff && (wr_addr == r_rs_addr_q)) begin
                r_rs_data <= wr_data;
            end
            if (w_weff && (wr_addr == r_rt_addr_q)) begin
                r_rt_data <= wr_data;
            end
        end else begin
            r_rs_data   <= w_rs_lookup;
            r_rt_data   <= w_rt_lookup;
            r_rs_addr_q <= rs_addr;
            r_rt_addr_q <= rt_addr;
        end
    end

    assign rs_data   = r_rs_data;
    assign rt_data   = r_rt_data;
    assign rs_addr_q = r_rs_addr_q;
    assign rt_addr_q = r_rt_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_read.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_read
// Brief    : Directed vector bench for reg_file_read.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_read;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int c_NVEC = 16;

    logic              clk;
    logic              rst_n;
    logic              stall;
    logic              flush;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [ADDR_W-1:0] rs_addr_q;
    logic [ADDR_W-1:0] rt_addr_q;

    int checks;
    int failures;

    typedef struct {
        logic              stall;
        logic              flush;
        logic              wr_en;
        logic [ADDR_W-1:0] wr_addr;
        logic [DATA_W-1:0] wr_data;
        logic [ADDR_W-1:0] rs_addr;
        logic [ADDR_W-1:0] rt_addr;
        logic [DATA_W-1:0] exp_rs;
        logic [DATA_W-1:0] exp_rt;
        logic [ADDR_W-1:0] exp_rsq;
        logic [ADDR_W-1:0] exp_rtq;
    } vec_t;

    vec_t vecs [c_NVEC];

    reg_file_read #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall    (stall),
        .flush    (flush),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .rs_addr_q(rs_addr_q),
        .rt_addr_q(rt_addr_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [DATA_W-1:0] ers, input logic [DATA_W-1:0] ert,
                           input logic [ADDR_W-1:0] ersq, input logic [ADDR_W-1:0] ertq);
        chk({tag, ".rs_data"},   rs_data, ers);
        chk({tag, ".rt_data"},   rt_data, ert);
        chk({tag, ".rs_addr_q"}, DATA_W'(rs_addr_q), DATA_W'(ersq));
        chk({tag, ".rt_addr_q"}, DATA_W'(rt_addr_q), DATA_W'(ertq));
    endtask

    task automatic drive(input logic s, input logic f, input logic we, input logic [ADDR_W-1:0] wa,
                         input logic [DATA_W-1:0] wd, input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb);
        stall   = s;
        flush   = f;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        rs_addr = ra;
        rt_addr = rb;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //          stall flush we  waddr  wdata         rs  rt   exp_rs        exp_rt        rsq rtq
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 32'h0,        32'h0,        5'd5,  5'd31};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 5'd8,  32'hDEADBEEF, 5'd0,  5'd0,  32'h0,        32'h0,        5'd0,  5'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        5'd8,  5'd8,  32'hDEADBEEF, 32'hDEADBEEF, 5'd8,  5'd8};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 5'd0,  32'h1234,     5'd0,  5'd8,  32'h0,        32'hDEADBEEF, 5'd0,  5'd8};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        5'd0,  5'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 5'd9,  32'hA5A5A5A5, 5'd9,  5'd9,  32'hA5A5A5A5, 32'hA5A5A5A5, 5'd9,  5'd9};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 5'd10, 32'h11,       5'd10, 5'd9,  32'h11,       32'hA5A5A5A5, 5'd10, 5'd9};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 5'd10, 32'h22,       5'd1,  5'd2,  32'h22,       32'hA5A5A5A5, 5'd10, 5'd9};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 5'd11, 32'h33,       5'd1,  5'd2,  32'h22,       32'hA5A5A5A5, 5'd10, 5'd9};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 5'd9,  32'h44,       5'd4,  5'd5,  32'h22,       32'h44,       5'd10, 5'd9};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 5'd3,  32'h77,       5'd11, 5'd3,  32'h33,       32'h77,       5'd11, 5'd3};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 5'd3,  32'h99,       5'd3,  5'd3,  32'h0,        32'h0,        5'd0,  5'd0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        5'd3,  5'd10, 32'h99,       32'h22,       5'd3,  5'd10};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 5'd3,  32'hFF,       5'd7,  5'd7,  32'h99,       32'h22,       5'd3,  5'd10};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 5'd0,  32'h0,        5'd8,  5'd9,  32'h0,        32'h0,        5'd0,  5'd0};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 5'd12, 32'h55,       5'd12, 5'd11, 32'h55,       32'h33,       5'd12, 5'd11};

        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 32'h0, 32'h0, 5'd0, 5'd0);
        rst_n = 1'b1;

        for (int i = 0; i < c_NVEC; i++) begin
            drive(vecs[i].stall, vecs[i].flush, vecs[i].wr_en, vecs[i].wr_addr,
                  vecs[i].wr_data, vecs[i].rs_addr, vecs[i].rt_addr);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].exp_rs, vecs[i].exp_rt, vecs[i].exp_rsq, vecs[i].exp_rtq);
        end

        // Asynchronous reset between edges clears outputs with no clock edge.
        drive(1'b0, 1'b0, 1'b0, '0, '0, 5'd12, 5'd11);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 32'h0, 32'h0, 5'd0, 5'd0);

        // A write presented while reset is held must not land.
        drive(1'b0, 1'b0, 1'b1, 5'd13, 32'h7, 5'd13, 5'd12);
        @(posedge clk);
        #1;
        chk_all("rst_hold", 32'h0, 32'h0, 5'd0, 5'd0);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 5'd12, 5'd13);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all("post_rst", 32'h0, 32'h0, 5'd12, 5'd13);

        // Write then read back on the next cycle, non-bypass path.
        drive(1'b0, 1'b0, 1'b1, 5'd31, 32'hCAFEF00D, 5'd0, 5'd1);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, '0, '0, 5'd31, 5'd12);
        @(posedge clk);
        #1;
        chk_all("r31_read", 32'hCAFEF00D, 32'h0, 5'd31, 5'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
